// File: rtl/psum_ofifo.sv
// -----------------------------------------------------------------------------
// psum_ofifo
//
// Multi-column output FIFO for MAC-array partial sums. Each column (lane)
// writes into its own FIFO on its own strobe. Reads are row-wide: a row is
// released only when every lane holds at least one sample. All lanes then
// pop together, and the row drives the sfp in/acc path.
//
// Parameters
//   col      number of lanes (MAC columns)
//   psum_bw  partial-sum width per lane
//   depth    entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   wr[col]     per-lane write strobe
//   in          packed lane data; lane k at [k*psum_bw +: psum_bw]
//   rd          row read request
//   out         registered row output, same packing as in
//   o_valid     every lane is non-empty (a row is readable)
//   o_full      at least one lane is full
//   o_ready     !o_full
//   o_overflow  sticky: a write hit a full lane and was dropped
//
// Handshake: a lane write is accepted when wr[k] is high and that lane is not
// full. A row read is accepted when rd and o_valid are both high. Both
// decisions use the flags as they stand before the clock edge, so a write and
// a read in the same cycle never see each other. rd without o_valid is
// ignored and is not an error. A write to a full lane is dropped and sets
// o_overflow.
// -----------------------------------------------------------------------------
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         wr,
    input  logic [col*psum_bw-1:0] in,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit, so full and empty can be told apart
    // without an occupancy counter.
    logic [aw:0]        wptr  [col];
    logic [aw:0]        rptr  [col];
    logic [psum_bw-1:0] mem   [col][depth];
    logic [psum_bw-1:0] row_q [col];

    logic [col-1:0] lane_empty;
    logic [col-1:0] lane_full;
    logic [col-1:0] wr_ok;
    logic           do_rd;

    always_comb begin
        lane_empty = '0;
        lane_full  = '0;
        for (int k = 0; k < col; k++) begin
            lane_empty[k] = (wptr[k] == rptr[k]);
            lane_full[k]  = (wptr[k][aw-1:0] == rptr[k][aw-1:0]) &&
                            (wptr[k][aw] != rptr[k][aw]);
        end
    end

    assign o_valid = &(~lane_empty);
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;

    // Full is taken from pre-edge state: a write to a full lane drops even
    // when the same edge pops that lane.
    assign wr_ok = wr & ~lane_full;
    assign do_rd = rd & o_valid;

    // Pointers, row register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < col; k++) begin
                wptr[k]  <= '0;
                rptr[k]  <= '0;
                row_q[k] <= '0;
            end
            o_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < col; k++) begin
                if (wr_ok[k]) begin
                    wptr[k] <= wptr[k] + ptr_one;
                end
                if (do_rd) begin
                    rptr[k]  <= rptr[k] + ptr_one;
                    row_q[k] <= mem[k][rptr[k][aw-1:0]];
                end
            end
            if (|(wr & lane_full)) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Lane storage has no reset; reset only has to block writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < col; k++) begin
                if (wr_ok[k]) begin
                    mem[k][wptr[k][aw-1:0]] <= in[k*psum_bw +: psum_bw];
                end
            end
        end
    end

    for (genvar g = 0; g < col; g++) begin : g_out
        assign out[g*psum_bw +: psum_bw] = row_q[g];
    end

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int RW    = COL * BW;

    logic          clk;
    logic          reset;
    logic [COL-1:0] wr;
    logic [RW-1:0] in_bus;
    logic          rd;
    logic [RW-1:0] out;
    logic          o_valid;
    logic          o_full;
    logic          o_ready;
    logic          o_overflow;

    int checks;
    int errors;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_row;
    logic [RW-1:0] last_row;

    psum_ofifo #(
        .col     (COL),
        .psum_bw (BW),
        .depth   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr),
        .in         (in_bus),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance one edge, then step away from it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr     = '0;
        rd     = 1'b0;
        in_bus = '0;
    endtask

    function automatic logic [RW-1:0] ramp_row(input int base);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = 16'(base + k);
        return r;
    endfunction

    function automatic logic [RW-1:0] flat_row(input logic [BW-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = v;
        return r;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();

        // Reset held for two cycles.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out", out, '0);
        check("rst_valid", RW'(o_valid), '0);
        check("rst_full", RW'(o_full), '0);
        check("rst_ready", RW'(o_ready), RW'(1));
        check("rst_ovf", RW'(o_overflow), '0);

        // Skewed fill: lane k gets 100+k at cycle k.
        for (int k = 0; k < COL; k++) begin
            wr        = '0;
            wr[k]     = 1'b1;
            in_bus    = ramp_row(100);
            tick();
            check($sformatf("skew_valid_%0d", k), RW'(o_valid), RW'(k == COL - 1));
        end
        idle_inputs();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        last_row = ramp_row(100);
        check("skew_out", out, last_row);
        check("skew_valid_after_rd", RW'(o_valid), '0);

        // Streaming with rd held high across three pointer wraps.
        for (int r = 0; r < 3 * DEPTH; r++) begin
            wr     = '1;
            rd     = 1'b1;
            in_bus = flat_row(16'((r % 16) - 8));
            exp_q.push_back(in_bus);
            tick();
            if (r >= 1) begin
                exp_row  = exp_q.pop_front();
                last_row = exp_row;
                check($sformatf("stream_row_%0d", r - 1), out, exp_row);
            end
        end
        wr = '0;
        tick();
        rd = 1'b0;
        exp_row  = exp_q.pop_front();
        last_row = exp_row;
        check("stream_last_row", out, exp_row);
        check("stream_drained", RW'(o_valid), '0);

        // Reset mid-stream with 5 rows queued; wr/rd in the reset cycle are ignored.
        for (int r = 0; r < 5; r++) begin
            wr     = '1;
            in_bus = ramp_row(500 + 10 * r);
            tick();
        end
        idle_inputs();
        check("queued_valid", RW'(o_valid), RW'(1));
        reset  = 1'b1;
        wr     = '1;
        rd     = 1'b1;
        in_bus = ramp_row(900);
        tick();
        reset = 1'b0;
        idle_inputs();
        check("midrst_out", out, '0);
        check("midrst_valid", RW'(o_valid), '0);
        check("midrst_full", RW'(o_full), '0);
        check("midrst_ready", RW'(o_ready), RW'(1));
        check("midrst_ovf", RW'(o_overflow), '0);
        wr     = '1;
        in_bus = ramp_row(600);
        tick();
        idle_inputs();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        last_row = ramp_row(600);
        check("midrst_new_row", out, last_row);
        check("midrst_only_new", RW'(o_valid), '0);

        // Fill lane 0 only: 64 writes make it full.
        for (int i = 0; i < DEPTH; i++) begin
            wr     = 8'h01;
            in_bus = ramp_row(1000 + i);
            tick();
        end
        idle_inputs();
        check("full_flag", RW'(o_full), RW'(1));
        check("full_ready", RW'(o_ready), '0);
        check("full_no_ovf_yet", RW'(o_overflow), '0);
        check("full_not_valid", RW'(o_valid), '0);
        wr     = 8'h01;
        in_bus = flat_row(16'hDEAD);
        tick();
        idle_inputs();
        check("ovf_set", RW'(o_overflow), RW'(1));
        for (int i = 0; i < 10; i++) tick();
        check("ovf_sticky", RW'(o_overflow), RW'(1));
        check("ovf_still_full", RW'(o_full), RW'(1));

        // rd with lane 3 empty: ignored, out holds, nothing moves.
        wr     = 8'b1111_0110;
        in_bus = ramp_row(200);
        tick();
        idle_inputs();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("lane3_empty_out_hold", out, last_row);
        check("lane3_empty_valid", RW'(o_valid), '0);
        check("lane3_empty_full", RW'(o_full), RW'(1));

        // Fill lane 3, then write+read on full lane 0: read pops, write drops.
        wr     = 8'b0000_1000;
        in_bus = flat_row(16'd300);
        tick();
        check("lane3_filled_valid", RW'(o_valid), RW'(1));
        wr     = 8'h01;
        in_bus = flat_row(16'hBEEF);
        rd     = 1'b1;
        tick();
        idle_inputs();
        exp_row = ramp_row(200);
        exp_row[0 +: BW]    = 16'd1000;
        exp_row[3*BW +: BW] = 16'd300;
        last_row = exp_row;
        check("full_wr_rd_out", out, exp_row);
        check("full_wr_dropped", RW'(o_full), '0);
        check("full_wr_rd_valid", RW'(o_valid), '0);

        // Write to the last empty lane with rd in the same cycle.
        wr     = 8'b0111_1110;
        in_bus = ramp_row(400);
        tick();
        wr     = 8'b1000_0000;
        in_bus = ramp_row(400);
        rd     = 1'b1;
        tick();
        idle_inputs();
        check("last_lane_rd_ignored", out, last_row);
        check("last_lane_valid", RW'(o_valid), RW'(1));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        exp_row = ramp_row(400);
        exp_row[0 +: BW] = 16'd1001;
        check("last_lane_row", out, exp_row);
        check("last_lane_drained", RW'(o_valid), '0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
